// File: rtl/ghost_dir_picker_if.sv
// Request/response bundle between a ghost controller and ghost_dir_picker.
// GHOST_DIR_PICKER_STATS_EN adds the reroll_cnt statistics signal.
interface ghost_dir_picker_if;
  logic       rand_bit;
  logic       req;
  logic [1:0] cur_dir;
  logic [3:0] wall_mask;
  logic       busy;
  logic       dir_valid;
  logic [1:0] dir_out;
`ifdef GHOST_DIR_PICKER_STATS_EN
  logic [7:0] reroll_cnt;

  modport master (output rand_bit, req, cur_dir, wall_mask,
                  input  busy, dir_valid, dir_out, reroll_cnt);
  modport slave  (input  rand_bit, req, cur_dir, wall_mask,
                  output busy, dir_valid, dir_out, reroll_cnt);
`else
  modport master (output rand_bit, req, cur_dir, wall_mask,
                  input  busy, dir_valid, dir_out);
  modport slave  (input  rand_bit, req, cur_dir, wall_mask,
                  output busy, dir_valid, dir_out);
`endif
endinterface

// File: rtl/ghost_dir_picker.sv
// Picks a legal ghost direction at a junction from an LFSR bitstream.
// Optional macro GHOST_DIR_PICKER_STATS_EN adds a saturating reroll counter.
module ghost_dir_picker #(
  parameter logic [1:0] DEFAULT_DIR   = 2'd0,
  parameter int         GATHER_CYCLES = 2
) (
  input logic              clk,
  input logic              reset,
  ghost_dir_picker_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_GATHER, S_TRY, S_DONE} state_t;

  localparam logic [3:0] LP_GLAST = 4'(GATHER_CYCLES - 1);

  state_t     r_state, w_next;
  logic [1:0] r_acc, r_cand, r_cur, r_dir_out;
  logic [3:0] r_cnt, r_allowed;
  logic       r_hold;

  logic [1:0] w_rev, w_acc_next;
  logic [3:0] w_rev_oh, w_allow_raw, w_allowed;
  logic       w_boxed, w_hit, w_dir_valid;

  // Never turn back unless it is the only open way out.
  assign w_rev       = bus.cur_dir ^ 2'd2;
  assign w_rev_oh    = 4'b0001 << w_rev;
  assign w_allow_raw = ~bus.wall_mask & ~w_rev_oh;
  assign w_allowed   = (w_allow_raw == 4'b0000 && !bus.wall_mask[w_rev]) ? w_rev_oh
                                                                          : w_allow_raw;
  assign w_boxed     = (bus.wall_mask == 4'b1111);
  assign w_hit       = r_allowed[r_cand];
  assign w_acc_next  = {r_acc[0], bus.rand_bit};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_dir_valid = 1'b0;
    case (r_state)
      S_IDLE:   if (bus.req) w_next = w_boxed ? S_DONE : S_GATHER;
      S_GATHER: if (r_cnt == LP_GLAST) w_next = S_TRY;
      S_TRY:    if (w_hit) w_next = S_DONE;
      S_DONE: begin
        // A boxed request spends one extra DONE cycle loading dir_out.
        if (!r_hold) begin
          w_dir_valid = 1'b1;
          w_next      = S_IDLE;
        end
      end
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc     <= 2'd0;
      r_cand    <= 2'd0;
      r_cur     <= 2'd0;
      r_cnt     <= 4'd0;
      r_allowed <= 4'd0;
      r_hold    <= 1'b0;
      r_dir_out <= DEFAULT_DIR;
    end else begin
      case (r_state)
        S_IDLE: if (bus.req) begin
          r_cur     <= bus.cur_dir;
          r_allowed <= w_allowed;
          r_hold    <= w_boxed;
          r_cnt     <= 4'd0;
        end
        S_GATHER: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == LP_GLAST) r_cand <= w_acc_next;
        end
        S_TRY: begin
          if (w_hit) r_dir_out <= r_cand;
          else       r_cand    <= r_cand + 2'd1;
        end
        S_DONE: if (r_hold) begin
          r_hold    <= 1'b0;
          r_dir_out <= r_cur;
        end
        default: ;
      endcase
    end
  end

`ifdef GHOST_DIR_PICKER_STATS_EN
  logic [7:0] r_reroll;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                          r_reroll <= 8'd0;
    else if (r_state == S_TRY && !w_hit && r_reroll != 8'hFF) r_reroll <= r_reroll + 8'd1;
  end

  assign bus.reroll_cnt = r_reroll;
`endif

  assign bus.busy      = (r_state != S_IDLE);
  assign bus.dir_valid = w_dir_valid;
  assign bus.dir_out   = r_dir_out;

endmodule
